// File: rtl/int_sync_crossing_source_multi_pkg.sv
// Shared definitions for the multi-channel interrupt crossing source:
// channel-kind lookup, enable-mask reset value and channel-count legality.
package int_xing_pkg;

  // Widest supported channel count; masks are held at this width here.
  localparam int unsigned MAX_INTS = 64;

  // Enable mask comes out of reset with every channel enabled.
  localparam logic [63:0] MASK_RESET = {64{1'b1}};

  // Returns 1 when channel idx is edge-captured, 0 when it is level.
  function automatic logic edge_chan(input logic [63:0] edge_mask,
                                     input logic [5:0]  idx);
    return edge_mask[idx];
  endfunction

  // Channel count must lie in 1..MAX_INTS.
  function automatic logic num_ints_legal(input int n);
    return (n >= 1) && (n <= 64);
  endfunction

endpackage

// File: rtl/int_sync_crossing_source_multi_chan_slice.sv
// One interrupt channel: previous-input copy, sticky pending bit (edge
// channels only) and the output flop feeding the crossing sink.
module int_chan_slice
  import int_xing_pkg::*;
#(
  parameter bit EDGE       = 1'b0,
  parameter bit REGISTERED = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_in,
  input  logic i_mask,
  input  logic i_clr,
  output logic o_pend,
  output logic o_out
);

  logic r_in_q;
  logic r_pend;
  logic r_out;
  logic w_rise;
  logic w_raw;

  // Rising edge only exists on edge channels; level channels never pend.
  assign w_rise = EDGE & i_in & ~r_in_q;

  // Value presented before the output flop, gated by the enable mask.
  assign w_raw = (EDGE ? r_pend : i_in) & i_mask;

  // Input history, sticky pending (new edge beats clear) and output flop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_in_q <= i_in;
      r_pend <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      r_in_q <= i_in;
      if (w_rise) begin
        r_pend <= 1'b1;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= r_pend;
      end
      r_out <= w_raw;
    end
  end

  // Edge channels always leave through the flop; level channels only when
  // the crossing is built registered.
  assign o_out  = (REGISTERED || EDGE) ? r_out : w_raw;
  assign o_pend = r_pend;

endmodule

// File: rtl/int_sync_crossing_source_multi.sv
// Source half of a multi-channel interrupt clock-domain crossing. Holds the
// software enable mask and fans the clear strobe out to per-channel slices.
module int_sync_crossing_source_multi
  import int_xing_pkg::*;
#(
  parameter int                  NUM_INTS   = 4,
  parameter logic [NUM_INTS-1:0] EDGE_MASK  = '0,
  parameter bit                  REGISTERED = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_INTS-1:0] auto_in,
  output logic [NUM_INTS-1:0] auto_out_sync,
  input  logic                clr_valid,
  input  logic [NUM_INTS-1:0] clr_mask,
  input  logic                mask_we,
  input  logic [NUM_INTS-1:0] mask_wdata,
  output logic [NUM_INTS-1:0] mask_q,
  output logic [NUM_INTS-1:0] pending
);

  // Reject unsupported channel counts while elaborating.
  if (!num_ints_legal(NUM_INTS)) begin : g_bad_num_ints
    $error("int_sync_crossing_source_multi: NUM_INTS must be 1..64");
  end

  logic [NUM_INTS-1:0] r_mask;
  logic [NUM_INTS-1:0] w_clr;
  logic [NUM_INTS-1:0] w_pend;
  logic [NUM_INTS-1:0] w_out;

  // Clear request per channel; level slices ignore it internally.
  assign w_clr = {NUM_INTS{clr_valid}} & clr_mask;

  // Enable mask: whole-word write, all channels enabled after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mask <= MASK_RESET[NUM_INTS-1:0];
    end else if (mask_we) begin
      r_mask <= mask_wdata;
    end else begin
      r_mask <= r_mask;
    end
  end

  for (genvar i = 0; i < NUM_INTS; i++) begin : g_chan
    int_chan_slice #(
      .EDGE       (edge_chan(64'(EDGE_MASK), 6'(i))),
      .REGISTERED (REGISTERED)
    ) u_slice (
      .clock  (clock),
      .reset  (reset),
      .i_in   (auto_in[i]),
      .i_mask (r_mask[i]),
      .i_clr  (w_clr[i]),
      .o_pend (w_pend[i]),
      .o_out  (w_out[i])
    );
  end

  assign auto_out_sync = w_out;
  assign pending       = w_pend;
  assign mask_q        = r_mask;

endmodule

// File: tb/tb_int_sync_crossing_source_multi.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a vector-level behavioural model of the crossing source.
module tb_int_sync_crossing_source_multi;

  localparam logic [3:0] EM = 4'b0011;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] auto_in = 4'b0000;
  logic [3:0] auto_out_sync;
  logic       clr_valid = 1'b0;
  logic [3:0] clr_mask = 4'b0000;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = 4'b0000;
  logic [3:0] mask_q;
  logic [3:0] pending;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [3:0] m_prev, m_pend, m_mask, m_out;

  int_sync_crossing_source_multi #(
    .NUM_INTS   (4),
    .EDGE_MASK  (EM),
    .REGISTERED (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .auto_in       (auto_in),
    .auto_out_sync (auto_out_sync),
    .clr_valid     (clr_valid),
    .clr_mask      (clr_mask),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .mask_q        (mask_q),
    .pending       (pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Model of one clock edge, from the behavioural rules of the block.
  task automatic model_edge();
    logic [3:0] rise, clr, raw;
    if (!reset) begin
      m_prev = auto_in;
      m_pend = 4'b0000;
      m_out  = 4'b0000;
      m_mask = 4'b1111;
    end else begin
      rise   = auto_in & ~m_prev & EM;
      clr    = clr_valid ? clr_mask : 4'b0000;
      raw    = ((EM & m_pend) | (~EM & auto_in)) & m_mask;
      m_out  = raw;
      m_pend = (rise | (m_pend & ~clr)) & EM;
      if (mask_we) m_mask = mask_wdata;
      m_prev = auto_in;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("model_out", auto_out_sync, m_out);
    chk("model_pend", pending, m_pend);
    chk("model_mask", mask_q, m_mask);
  endtask

  initial begin
    // Reset hold with all inputs high, then release: no edges captured.
    reset = 1'b0; auto_in = 4'b1111;
    tick(); tick();
    chk("rst_out", auto_out_sync, 4'b0000);
    chk("rst_pend", pending, 4'b0000);
    chk("rst_mask", mask_q, 4'b1111);
    reset = 1'b1;
    tick();
    chk("release_out", auto_out_sync, 4'b1100);
    chk("release_pend", pending, 4'b0000);

    // Level channel 2.
    auto_in = 4'b0000; tick(); tick();
    auto_in = 4'b0100; tick();
    chk("lvl2_high", {3'b000, auto_out_sync[2]}, 4'b0001);
    auto_in = 4'b0000; tick();
    chk("lvl2_low", {3'b000, auto_out_sync[2]}, 4'b0000);

    // Edge channel 0 pulse, hold, then clear.
    auto_in = 4'b0001; tick();
    chk("e0_pend", pending, 4'b0001);
    chk("e0_out_t1", auto_out_sync, 4'b0000);
    auto_in = 4'b0000; tick();
    chk("e0_out_t2", auto_out_sync, 4'b0001);
    tick();
    chk("e0_sticky", {pending[0], auto_out_sync[0]}, 2'b11);
    clr_valid = 1'b1; clr_mask = 4'b0001; tick();
    clr_valid = 1'b0; clr_mask = 4'b0000;
    chk("e0_clr_pend", pending, 4'b0000);
    chk("e0_clr_out_t1", auto_out_sync, 4'b0001);
    tick();
    chk("e0_clr_out_t2", auto_out_sync, 4'b0000);

    // Channel 1: rise simultaneous with clear keeps the event.
    auto_in = 4'b0010; tick();
    auto_in = 4'b0000; tick(); tick();
    auto_in = 4'b0010; clr_valid = 1'b1; clr_mask = 4'b0010; tick();
    clr_valid = 1'b0; clr_mask = 4'b0000;
    chk("e1_set_wins", pending, 4'b0010);
    auto_in = 4'b0000; tick();
    chk("e1_out_held", auto_out_sync, 4'b0010);

    // Mask off channel 0 while it pends, then re-enable.
    auto_in = 4'b0001; tick();
    auto_in = 4'b0000; tick();
    mask_we = 1'b1; mask_wdata = 4'b1110; tick();
    mask_we = 1'b0;
    chk("mask_q_1110", mask_q, 4'b1110);
    tick();
    chk("masked_out0", {pending[0], auto_out_sync[0]}, 2'b10);
    mask_we = 1'b1; mask_wdata = 4'b1111; tick();
    mask_we = 1'b0;
    chk("unmask_t1", {3'b000, auto_out_sync[0]}, 4'b0000);
    tick();
    chk("unmask_t2", {3'b000, auto_out_sync[0]}, 4'b0001);

    // Mid-operation reset discards pending events.
    chk("pre_rst_pend", pending, 4'b0011);
    mask_we = 1'b1; mask_wdata = 4'b0101;
    reset = 1'b0; tick();
    mask_we = 1'b0;
    chk("midrst_out", auto_out_sync, 4'b0000);
    chk("midrst_pend", pending, 4'b0000);
    chk("midrst_mask", mask_q, 4'b1111);
    reset = 1'b1; tick();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      auto_in    = 4'($urandom_range(0, 15));
      clr_valid  = ($urandom_range(0, 3) == 0);
      clr_mask   = 4'($urandom_range(0, 15));
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = 4'($urandom_range(0, 15));
      reset      = ($urandom_range(0, 39) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
